ddr_lane_delay_ctrl: RTL and testbench

Parametrised controller for the dynamic output delay lines of a group of DDR PHY IOD lanes (command/address, data). Accepts one delay request at a time for a selected lane and converts it into the IOD MOVE/DIRECTION/LOAD pulse sequence with required spacing. Tracks the current tap of every lane, clamps at range limits and honours the IOD out-of-range flag. Sits between the training/calibration sequencer and the per-lane IOD instances in the DDRPHY block.

---
 rtl/ddr_lane_delay_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_ddr_lane_delay_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_lane_delay_ctrl.sv
// DDR PHY IOD output-delay controller. It converts one tap request at a time into
// DIRECTION/MOVE/LOAD pulses for the selected lane and tracks the tap of every lane.
module ddr_lane_delay_ctrl #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_IDX_W = 3,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int INIT_TAP   = 1,
  parameter int MOVE_GAP   = 2
) (
  input  logic                  fab_clk_i,
  input  logic                  arst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [LANE_IDX_W-1:0] req_lane_i,
  input  logic [1:0]            req_mode_i,
  input  logic [TAP_W-1:0]      req_value_i,
  output logic                  done_o,
  output logic                  done_err_o,
  output logic                  busy_o,
  output logic [NUM_LANES-1:0]  delay_line_move_o,
  output logic [NUM_LANES-1:0]  delay_line_direction_o,
  output logic [NUM_LANES-1:0]  delay_line_load_o,
  input  logic [NUM_LANES-1:0]  delay_line_out_of_range_i,
  input  logic [LANE_IDX_W-1:0] tap_sel_i,
  output logic [TAP_W-1:0]      tap_value_o
);

  localparam logic [TAP_W-1:0] MAX_TAP_C  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_TAP_C = TAP_W'(INIT_TAP);
  localparam int               GAP_W      = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'((MOVE_GAP > 0) ? (MOVE_GAP - 1) : 0);

  localparam logic [1:0] MODE_INC = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_CHECK, S_GAP, S_LOAD, S_FIN
  } state_e;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_LANES; i++) oh[i] = (lane == LANE_IDX_W'(i));
    return oh;
  endfunction

  state_e                state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic                  dir_q, dir_d;
  logic [TAP_W-1:0]      steps_q, steps_d;
  logic                  err_q, err_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [TAP_W-1:0]      tap_q [NUM_LANES];
  logic [TAP_W-1:0]      tap_d [NUM_LANES];

  logic [NUM_LANES-1:0]  move_q, load_q, line_dir_q;
  logic                  done_q, done_err_q, ready_q, busy_q;

  logic [TAP_W-1:0]      cur_tap_s, room_s, plan_steps_s;
  logic                  plan_dir_s, plan_err_s, lane_ok_s, oor_hit_s;
  logic [NUM_LANES-1:0]  lane_oh_s, lane_oh_d_s;

  assign lane_ok_s   = (32'(req_lane_i) < NUM_LANES);
  assign lane_oh_s   = lane_onehot(lane_q);
  assign lane_oh_d_s = lane_onehot(lane_d);
  assign oor_hit_s   = |(delay_line_out_of_range_i & lane_oh_s);

  // Current tap of the requested lane and readback mux (0 for lanes that do not exist)
  always_comb begin
    cur_tap_s   = '0;
    tap_value_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cur_tap_s   |= (req_lane_i == LANE_IDX_W'(i)) ? tap_q[i] : '0;
      tap_value_o |= (tap_sel_i == LANE_IDX_W'(i)) ? tap_q[i] : '0;
    end
  end

  // Request planning: direction, clamped step count and clamp error
  always_comb begin
    plan_dir_s   = 1'b1;
    plan_steps_s = '0;
    plan_err_s   = 1'b0;
    room_s       = MAX_TAP_C - cur_tap_s;
    case (req_mode_i)
      MODE_INC: begin
        plan_dir_s = 1'b1;
        if (req_value_i > room_s) begin
          plan_steps_s = room_s;
          plan_err_s   = 1'b1;
        end else begin
          plan_steps_s = req_value_i;
        end
      end
      MODE_DEC: begin
        plan_dir_s = 1'b0;
        if (req_value_i > cur_tap_s) begin
          plan_steps_s = cur_tap_s;
          plan_err_s   = 1'b1;
        end else begin
          plan_steps_s = req_value_i;
        end
      end
      MODE_ABS: begin
        if (32'(req_value_i) > MAX_TAP) begin
          plan_err_s = 1'b1;
        end else if (req_value_i > cur_tap_s) begin
          plan_dir_s   = 1'b1;
          plan_steps_s = req_value_i - cur_tap_s;
        end else begin
          plan_dir_s   = 1'b0;
          plan_steps_s = cur_tap_s - req_value_i;
        end
      end
      default: begin
        plan_dir_s = 1'b1;
      end
    endcase
  end

  // Sequencer next state, step bookkeeping and tap tracking
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    err_d   = err_q;
    gap_d   = gap_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          lane_d  = req_lane_i;
          dir_d   = plan_dir_s;
          steps_d = plan_steps_s;
          err_d   = plan_err_s;
          gap_d   = '0;
          if (!lane_ok_s) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (req_mode_i == 2'b11) begin
            state_d = S_LOAD;
          end else if (plan_steps_s == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SETUP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: state_d = S_MOVE;
      S_MOVE:  state_d = S_CHECK;
      S_CHECK: begin
        if (oor_hit_s) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_oh_s[i]) begin
              tap_d[i] = dir_q ? (tap_q[i] + TAP_W'(1)) : (tap_q[i] - TAP_W'(1));
            end else begin
              tap_d[i] = tap_q[i];
            end
          end
          steps_d = steps_q - TAP_W'(1);
          if (steps_q == TAP_W'(1)) begin
            state_d = S_FIN;
          end else if (MOVE_GAP == 0) begin
            state_d = S_MOVE;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST_C) begin
          state_d = S_MOVE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_LOAD: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_oh_s[i]) begin
            tap_d[i] = INIT_TAP_C;
          end else begin
            tap_d[i] = tap_q[i];
          end
        end
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and outputs; pulses are decoded from the next state so they line up with it
  always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      dir_q      <= 1'b0;
      steps_q    <= '0;
      err_q      <= 1'b0;
      gap_q      <= '0;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= INIT_TAP_C;
      move_q     <= '0;
      load_q     <= '0;
      line_dir_q <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      dir_q      <= dir_d;
      steps_q    <= steps_d;
      err_q      <= err_d;
      gap_q      <= gap_d;
      tap_q      <= tap_d;
      move_q     <= (state_d == S_MOVE) ? lane_oh_d_s : '0;
      load_q     <= (state_d == S_LOAD) ? lane_oh_d_s : '0;
      if (state_d == S_SETUP) begin
        line_dir_q <= (line_dir_q & ~lane_oh_d_s) | (lane_oh_d_s & {NUM_LANES{dir_d}});
      end else begin
        line_dir_q <= line_dir_q;
      end
      done_q     <= (state_d == S_FIN);
      done_err_q <= (state_d == S_FIN) & err_d;
      ready_q    <= (state_d == S_IDLE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign req_ready_o            = ready_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign done_err_o             = done_err_q;
  assign delay_line_move_o      = move_q;
  assign delay_line_load_o      = load_q;
  assign delay_line_direction_o = line_dir_q;

endmodule

// File: tb/tb_ddr_lane_delay_ctrl.sv
// Bench for ddr_lane_delay_ctrl: directed and random requests checked against a
// tap/timing model derived from the request rules.
`timescale 1ns/1ps
module tb_ddr_lane_delay_ctrl;
  localparam int NL = 8, LW = 4, TW = 8, MAXT = 255, INIT = 1, GAP = 2;
  localparam int PER = GAP + 2, BUDGET = 3000;

  logic clk = 1'b0, arst_n = 1'b0, req_valid = 1'b0;
  logic req_ready, done, done_err, busy;
  logic [LW-1:0] req_lane = '0, tap_sel = '0;
  logic [1:0]    req_mode = '0;
  logic [TW-1:0] req_value = '0, tap_value;
  logic [NL-1:0] mv, dirv, ld, oor = '0;

  int total = 0, bad = 0;
  int taps[NL];
  logic [NL-1:0] exp_dirv;

  always #5 clk = ~clk;

  ddr_lane_delay_ctrl #(
    .NUM_LANES(NL), .LANE_IDX_W(LW), .TAP_W(TW), .MAX_TAP(MAXT), .INIT_TAP(INIT), .MOVE_GAP(GAP)
  ) dut (
    .fab_clk_i(clk), .arst_n_i(arst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_lane_i(req_lane), .req_mode_i(req_mode), .req_value_i(req_value),
    .done_o(done), .done_err_o(done_err), .busy_o(busy),
    .delay_line_move_o(mv), .delay_line_direction_o(dirv), .delay_line_load_o(ld),
    .delay_line_out_of_range_i(oor), .tap_sel_i(tap_sel), .tap_value_o(tap_value)
  );

  task automatic reset_model();
    for (int i = 0; i < NL; i++) taps[i] = INIT;
    exp_dirv = '0;
  endtask

  task automatic check_all_taps(input string tag);
    int want;
    for (int i = 0; i < NL + 2; i++) begin
      tap_sel = LW'(i);
      #1;
      want = (i < NL) ? taps[i] : 0;
      total++;
      if (tap_value !== TW'(want)) begin
        bad++;
        $display("FAIL %s tap[%0d]: got %0d want %0d", tag, i, tap_value, want);
      end
    end
  endtask

  // One request: model predicts moves, timing, error and final tap, then the DUT is watched
  task automatic run_req(input int lane, input int mode, input int value, input int oor_at,
                         input bit hold, input string tag);
    int cur, n, nm, moved, err, dir, exp_done, exp_loads, exp_tap, got_done, moves, loads, last_mv;
    logic got_err;
    bit bad_mv, bad_ld, bad_ctl;
    logic [NL-1:0] mask, exp_dv;
    mask = '0;
    cur = 0;
    if (lane < NL) begin
      mask[lane] = 1'b1;
      cur = taps[lane];
    end
    n = 0; err = 0; dir = 1; exp_loads = 0;
    if (lane >= NL) err = 1;
    else begin
      case (mode)
        0: begin dir = 1; err = (value > MAXT - cur) ? 1 : 0; n = err ? MAXT - cur : value; end
        1: begin dir = 0; err = (value > cur) ? 1 : 0; n = err ? cur : value; end
        2: begin
          if (value > MAXT) err = 1;
          else begin dir = (value > cur) ? 1 : 0; n = dir ? value - cur : cur - value; end
        end
        default: exp_loads = 1;
      endcase
    end
    nm = n; moved = n;
    if (oor_at > 0 && oor_at <= n) begin nm = oor_at; moved = oor_at - 1; err = 1; end
    exp_tap  = (lane >= NL) ? 0 : (exp_loads == 1) ? INIT : (dir == 1) ? cur + moved : cur - moved;
    exp_done = (exp_loads == 1) ? 2 : (nm == 0) ? 1 : 4 + (nm - 1) * PER;
    exp_dv = exp_dirv;
    if (n > 0) exp_dv[lane] = dir[0];

    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", tag, req_ready); end
    req_valid = 1'b1; req_lane = LW'(lane); req_mode = 2'(mode); req_value = TW'(value);
    @(posedge clk);
    #1;
    if (hold) begin
      req_lane = LW'($urandom); req_mode = 2'($urandom); req_value = TW'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    got_done = -1; got_err = 1'bx; moves = 0; loads = 0; last_mv = -10;
    bad_mv = 0; bad_ld = 0; bad_ctl = 0;
    for (int t = 1; t <= BUDGET; t++) begin
      @(negedge clk);
      if (mv !== '0) begin
        moves++; last_mv = t;
        if (mv !== mask || t != 2 + (moves - 1) * PER) bad_mv = 1;
      end
      if (ld !== '0) begin
        loads++;
        if (ld !== mask || t != 1) bad_ld = 1;
      end
      if (dirv !== exp_dv || req_ready !== 1'b0 || busy !== 1'b1) bad_ctl = 1;
      if (done === 1'b1) begin got_done = t; got_err = done_err; break; end
      // out-of-range noise is free outside CHECK; in CHECK the selected lane follows oor_at
      oor = NL'($urandom);
      if (t == last_mv + 1) oor = (oor & ~mask) | ((oor_at > 0 && moves == oor_at) ? mask : '0);
    end
    oor = '0;
    if (hold) req_valid = 1'b0;

    total++;
    if (got_done != exp_done) begin bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, got_done, exp_done); end
    total++;
    if (got_err !== err[0]) begin bad++; $display("FAIL %s done_err: got %b want %0d", tag, got_err, err); end
    total++;
    if (moves != nm || bad_mv) begin bad++; $display("FAIL %s moves: got %0d (shape_bad=%0d) want %0d", tag, moves, bad_mv, nm); end
    total++;
    if (loads != exp_loads || bad_ld) begin bad++; $display("FAIL %s loads: got %0d (shape_bad=%0d) want %0d", tag, loads, bad_ld, exp_loads); end
    total++;
    if (bad_ctl) begin bad++; $display("FAIL %s busy_dir: dir=%b want %b ready=%b busy=%b", tag, dirv, exp_dv, req_ready, busy); end
    tap_sel = LW'(lane);
    #1;
    total++;
    if (tap_value !== TW'(exp_tap)) begin bad++; $display("FAIL %s tap: got %0d want %0d", tag, tap_value, exp_tap); end
    if (lane < NL) taps[lane] = exp_tap;
    exp_dirv = exp_dv;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; req_valid = 1'b0; oor = '0;
    repeat (2) @(negedge clk);
    reset_model();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || done_err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: ready=%b busy=%b done=%b err=%b want 1 0 0 0", req_ready, busy, done, done_err);
    end
    total++;
    if (mv !== '0 || ld !== '0 || dirv !== '0) begin
      bad++; $display("FAIL reset_lines: move=%b load=%b dir=%b want all 0", mv, ld, dirv);
    end
    check_all_taps("reset");
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Start lane increment of 3 and pull reset at cycle k+cyc
  task automatic reset_during(input int lane, input int cyc, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_lane = LW'(lane); req_mode = 2'b00; req_value = TW'(3);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    arst_n = 1'b0;
    #1;
    total++;
    if (mv !== '0 || ld !== '0 || done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || dirv !== '0) begin
      bad++; $display("FAIL %s: move=%b load=%b done=%b ready=%b busy=%b dir=%b", tag, mv, ld, done, req_ready, busy, dirv);
    end
    reset_model();
    check_all_taps(tag);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_increment();
    run_req(3, 0, 3, 0, 1'b0, "inc3");
  endtask

  task automatic test_absolute_and_clamp();
    run_req(0, 2, 0, 0, 1'b0, "abs0");
    run_req(0, 1, 5, 0, 1'b0, "dec_clamp");
  endtask

  task automatic test_upper_clamp();
    run_req(5, 2, 253, 0, 1'b0, "abs253");
    run_req(5, 0, 10, 0, 1'b0, "inc_clamp");
  endtask

  task automatic test_out_of_range();
    run_req(2, 0, 4, 2, 1'b0, "oor_abort");
  endtask

  task automatic test_load_bad_lane();
    run_req(7, 0, 2, 0, 1'b0, "pre_load");
    run_req(7, 3, 0, 0, 1'b0, "load7");
    run_req(9, 0, 1, 0, 1'b0, "bad_lane");
  endtask

  task automatic test_back_to_back();
    int lane, mode, value, oor_at, cur, d;
    run_req(4, 0, 3, 0, 1'b1, "hold_busy");
    for (int r = 0; r < 40; r++) begin
      lane = $urandom_range(0, NL + 1);
      mode = $urandom_range(0, 3);
      cur = 0;
      if (lane < NL) cur = taps[lane];
      if (mode == 2) begin
        d = $urandom_range(0, 20);
        value = cur + d - 10;
        if (value < 0) value = 0;
        if (value > MAXT) value = MAXT;
      end else begin
        value = $urandom_range(0, 12);
      end
      oor_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_req(lane, mode, value, oor_at, 1'($urandom_range(0, 1)), "rand");
    end
    check_all_taps("rand_end");
  endtask

  task automatic test_reset_mid_sequence();
    reset_during(3, 4, "reset_gap");
    reset_during(6, 2, "reset_move");
    run_req(3, 0, 1, 0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_increment();
    test_absolute_and_clamp();
    test_upper_clamp();
    test_out_of_range();
    test_load_bad_lane();
    test_back_to_back();
    test_reset_mid_sequence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
